// File: rtl/axi4_rd_dma_pkg.sv
// Shared AXI constants, controller state encoding and the per-lane keep helper
// used by the AXI4 read DMA.
package axi4_rd_dma_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         PAGE_SIZE_B = 4096;
  localparam int         PAGE_OFF_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte lane idx is kept on the final beat; rem_b == 0 means a full word.
  function automatic logic keep_bit(input int unsigned idx, input int unsigned rem_b);
    return (rem_b == 0) || (idx < rem_b);
  endfunction

endpackage

// File: rtl/axi4_rd_burst_gen.sv
// AR channel generator: splits the remaining words into INCR bursts limited by
// the burst length and 4 KB pages, and tracks bursts still in flight.
module axi4_rd_burst_gen
  import axi4_rd_dma_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int WORD_W          = 12,
  parameter int OFF_W           = 3,
  parameter int MAX_BURST_LEN   = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [WORD_W-1:0]     start_words_i,
  input  logic                  enable_i,
  input  logic                  rlast_hs_i,
  output logic                  arvalid_o,
  input  logic                  arready_i,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [7:0]            arlen_o
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW    = (WORD_W > PAGE_OFF_W + 1) ? WORD_W : PAGE_OFF_W + 1;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic [WORD_W-1:0]     words_req_reg;
  logic [OUT_W-1:0]      outstanding_reg;
  logic                  arvalid_reg;
  logic [7:0]            arlen_reg;
  logic [CW-1:0]         beats_reg;
  logic [CW-1:0]         page_words;
  logic [CW-1:0]         words_cw;
  logic [CW-1:0]         burst_cap;
  logic [CW-1:0]         beats_next;
  logic                  issue;
  logic                  ar_hs;

  // Words left before the next 4 KB boundary.
  assign page_words = CW'((13'(PAGE_SIZE_B) - {1'b0, addr_reg[PAGE_OFF_W-1:0]}) >> OFF_W);
  assign words_cw   = CW'(words_req_reg);
  assign burst_cap  = (words_cw < CW'(MAX_BURST_LEN)) ? words_cw : CW'(MAX_BURST_LEN);
  assign beats_next = (page_words < burst_cap) ? page_words : burst_cap;

  assign ar_hs = arvalid_reg && arready_i;
  assign issue = enable_i && !arvalid_reg && (words_req_reg != '0)
              && (outstanding_reg < OUT_W'(MAX_OUTSTANDING));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_reg        <= '0;
      araddr_reg      <= '0;
      words_req_reg   <= '0;
      outstanding_reg <= '0;
      arvalid_reg     <= 1'b0;
      arlen_reg       <= '0;
      beats_reg       <= '0;
    end else begin
      if (start_i) begin
        addr_reg      <= start_addr_i;
        words_req_reg <= start_words_i;
      end else if (ar_hs) begin
        addr_reg      <= addr_reg + (ADDR_WIDTH'(beats_reg) << OFF_W);
        words_req_reg <= words_req_reg - WORD_W'(beats_reg);
      end

      if (issue) begin
        arvalid_reg <= 1'b1;
        araddr_reg  <= addr_reg;
        arlen_reg   <= 8'(beats_next - CW'(1));
        beats_reg   <= beats_next;
      end else if (ar_hs) begin
        arvalid_reg <= 1'b0;
      end

      case ({ar_hs, rlast_hs_i})
        2'b10:   outstanding_reg <= outstanding_reg + OUT_W'(1);
        2'b01:   outstanding_reg <= outstanding_reg - OUT_W'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  assign arvalid_o = arvalid_reg;
  assign araddr_o  = araddr_reg;
  assign arlen_o   = arlen_reg;

endmodule

// File: rtl/axi4_rd_dma_stream.sv
// AXI4 read DMA: one command becomes one AXI4-Stream packet built from the
// returned read beats, followed by a one-cycle done/error report.
module axi4_rd_dma_stream
  import axi4_rd_dma_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int TDEST_WIDTH        = 4,
  parameter int TUSER_WIDTH        = 1,
  parameter int MAX_PKT_SIZE_B     = 8192,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B) + 1,
  parameter int MAX_BURST_LEN      = 256,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr_i,
  input  logic [MAX_PKT_SIZE_WIDTH-1:0] cmd_size_i,
  input  logic [TDEST_WIDTH-1:0]        cmd_tdest_i,
  output logic                          done_o,
  output logic                          err_o,
  output logic [DATA_WIDTH-1:0]         pkt_tdata,
  output logic [DATA_WIDTH/8-1:0]       pkt_tkeep,
  output logic [DATA_WIDTH/8-1:0]       pkt_tstrb,
  output logic                          pkt_tlast,
  output logic                          pkt_tvalid,
  input  logic                          pkt_tready,
  output logic [ID_WIDTH-1:0]           pkt_tid,
  output logic [TDEST_WIDTH-1:0]        pkt_tdest,
  output logic [TUSER_WIDTH-1:0]        pkt_tuser,
  output logic [ID_WIDTH-1:0]           mem_arid,
  output logic [ADDR_WIDTH-1:0]         mem_araddr,
  output logic [7:0]                    mem_arlen,
  output logic [2:0]                    mem_arsize,
  output logic [1:0]                    mem_arburst,
  output logic                          mem_arlock,
  output logic [3:0]                    mem_arcache,
  output logic [2:0]                    mem_arprot,
  output logic [3:0]                    mem_arqos,
  output logic                          mem_arvalid,
  input  logic                          mem_arready,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  input  logic [1:0]                    mem_rresp,
  input  logic                          mem_rlast,
  input  logic                          mem_rvalid,
  output logic                          mem_rready,
  output logic                          mem_awvalid,
  output logic                          mem_wvalid,
  output logic                          mem_bready
);

  localparam int DATA_B = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(DATA_B);
  localparam int WORD_W = MAX_PKT_SIZE_WIDTH - OFF_W + 1;
  localparam int SRW    = MAX_PKT_SIZE_WIDTH + 1;

  if (DATA_WIDTH < 16 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 || MAX_BURST_LEN < 1
      || MAX_BURST_LEN > 256 || (MAX_BURST_LEN & (MAX_BURST_LEN - 1)) != 0
      || MAX_OUTSTANDING < 1 || MAX_PKT_SIZE_B > (1 << (MAX_PKT_SIZE_WIDTH - 1))) begin : g_bad_params
    $error("axi4_rd_dma_stream: illegal parameter combination");
  end

  state_t                  state_reg, state_next;
  logic                    ready_en_reg;
  logic [WORD_W-1:0]       words_total_reg;
  logic [WORD_W-1:0]       beats_rcv_reg;
  logic [DATA_B-1:0]       last_keep_reg;
  logic [DATA_B-1:0]       last_keep_next;
  logic [TDEST_WIDTH-1:0]  tdest_reg;
  logic                    err_reg;
  logic [SRW-1:0]          size_round;
  logic [WORD_W-1:0]       cmd_words;
  logic                    cmd_hs;
  logic                    busy;
  logic                    r_hs;
  logic                    last_beat;

  assign size_round = {1'b0, cmd_size_i} + SRW'(DATA_B - 1);
  assign cmd_words  = WORD_W'(size_round >> OFF_W);

  for (genvar gi = 0; gi < DATA_B; gi++) begin : g_keep
    assign last_keep_next[gi] = keep_bit(gi, 32'(cmd_size_i[OFF_W-1:0]));
  end

  assign busy      = (state_reg == ST_BUSY);
  assign cmd_hs    = cmd_valid_i && cmd_ready_o;
  assign r_hs      = mem_rvalid && mem_rready;
  assign last_beat = (beats_rcv_reg == words_total_reg - WORD_W'(1));

  always_comb begin
    state_next  = state_reg;
    cmd_ready_o = ready_en_reg && (state_reg == ST_IDLE);
    done_o      = (state_reg == ST_DONE);
    err_o       = (state_reg == ST_DONE) && err_reg;
    case (state_reg)
      ST_IDLE: if (cmd_hs) state_next = (cmd_size_i == '0) ? ST_DONE : ST_BUSY;
      ST_BUSY: if (r_hs && last_beat) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg       <= ST_IDLE;
      ready_en_reg    <= 1'b0;
      words_total_reg <= '0;
      beats_rcv_reg   <= '0;
      last_keep_reg   <= '0;
      tdest_reg       <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      if (cmd_hs) begin
        words_total_reg <= cmd_words;
        beats_rcv_reg   <= '0;
        last_keep_reg   <= last_keep_next;
        tdest_reg       <= cmd_tdest_i;
        err_reg         <= 1'b0;
      end else if (r_hs) begin
        beats_rcv_reg <= beats_rcv_reg + WORD_W'(1);
        if (mem_rresp != RESP_OKAY) err_reg <= 1'b1;
      end
    end
  end

  axi4_rd_burst_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .WORD_W          (WORD_W),
    .OFF_W           (OFF_W),
    .MAX_BURST_LEN   (MAX_BURST_LEN),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_burst_gen (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .start_i       (cmd_hs),
    .start_addr_i  (cmd_addr_i & ~ADDR_WIDTH'(DATA_B - 1)),
    .start_words_i (cmd_words),
    .enable_i      (busy),
    .rlast_hs_i    (r_hs && mem_rlast),
    .arvalid_o     (mem_arvalid),
    .arready_i     (mem_arready),
    .araddr_o      (mem_araddr),
    .arlen_o       (mem_arlen)
  );

  assign mem_arid    = '0;
  assign mem_arsize  = 3'(OFF_W);
  assign mem_arburst = BURST_INCR;
  assign mem_arlock  = 1'b0;
  assign mem_arcache = 4'd0;
  assign mem_arprot  = 3'd0;
  assign mem_arqos   = 4'd0;
  assign mem_awvalid = 1'b0;
  assign mem_wvalid  = 1'b0;
  assign mem_bready  = 1'b1;

  // Read data passes straight through to the stream with no added latency.
  assign mem_rready = pkt_tready && busy;
  assign pkt_tvalid = mem_rvalid && busy;
  assign pkt_tdata  = mem_rdata;
  assign pkt_tlast  = last_beat;
  assign pkt_tkeep  = last_beat ? last_keep_reg : '1;
  assign pkt_tstrb  = last_beat ? last_keep_reg : '1;
  assign pkt_tdest  = tdest_reg;
  assign pkt_tid    = '0;
  assign pkt_tuser  = '0;

endmodule
